// File: rtl/basic_layer_search.sv
// Integer-pel full-search SAD engine for one 32x32 current block.
// Ports: clk, rst_n (async, active-high), ref_input (one 32-pixel reference row),
//   current_64pixels (two current rows), ref_begin_prepare / pe_begin_prepare (accept strobes),
//   SAD4x8..SAD32x32 (registered top-left partition SADs),
//   search_column_count / search_row_count (candidate tag for the SAD outputs).
module basic_layer_search #(
  parameter int SEARCH_ROWS = 16,
  parameter int SEARCH_COLS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [255:0]                   ref_input,
  input  logic [511:0]                   current_64pixels,
  input  logic                           ref_begin_prepare,
  input  logic                           pe_begin_prepare,
  output logic [12:0]                    SAD4x8,
  output logic [12:0]                    SAD8x4,
  output logic [13:0]                    SAD8x8,
  output logic [14:0]                    SAD8x16,
  output logic [14:0]                    SAD16x8,
  output logic [15:0]                    SAD16x16,
  output logic [17:0]                    SAD32x32,
  output logic [$clog2(SEARCH_COLS)-1:0] search_column_count,
  output logic [$clog2(SEARCH_ROWS)-1:0] search_row_count
);

  localparam int T   = 31 + SEARCH_ROWS;
  localparam int RCW = $clog2(T + 1);
  localparam int RW  = $clog2(SEARCH_ROWS);
  localparam int CW  = $clog2(SEARCH_COLS);

  logic [255:0]   cur_buf [32];
  logic [255:0]   ref_buf [32];
  logic [4:0]     load_cnt;
  logic           cur_loaded;
  logic [RCW-1:0] row_cnt;
  logic [CW-1:0]  col;

  logic [17:0] s4x8, s8x4, s8x8, s8x16, s16x8, s16x16, s32x32;
  logic [RCW-1:0] k_off;
  logic           capture;

  // Full 32x32 absolute-difference sum; partition sums are the
  // top-left sub-windows of the same pixel loop.
  always_comb begin
    logic [7:0] a, b, d;
    a = '0;
    b = '0;
    d = '0;
    s4x8   = '0;
    s8x4   = '0;
    s8x8   = '0;
    s8x16  = '0;
    s16x8  = '0;
    s16x16 = '0;
    s32x32 = '0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        a = cur_buf[r][8*c +: 8];
        b = ref_buf[r][8*c +: 8];
        d = (a > b) ? (a - b) : (b - a);
        s32x32 = s32x32 + 18'(d);
        if (r < 8  && c < 4)  s4x8   = s4x8   + 18'(d);
        if (r < 4  && c < 8)  s8x4   = s8x4   + 18'(d);
        if (r < 8  && c < 8)  s8x8   = s8x8   + 18'(d);
        if (r < 16 && c < 8)  s8x16  = s8x16  + 18'(d);
        if (r < 8  && c < 16) s16x8  = s16x8  + 18'(d);
        if (r < 16 && c < 16) s16x16 = s16x16 + 18'(d);
      end
    end
  end

  // A candidate exists once 32 rows of the column are in the buffer.
  assign capture = ref_begin_prepare && cur_loaded
                   && (row_cnt >= RCW'(32));
  assign k_off = row_cnt - RCW'(32);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cur_buf[i] <= '0;
        ref_buf[i] <= '0;
      end
      load_cnt   <= '0;
      cur_loaded <= 1'b0;
      row_cnt    <= '0;
      col        <= '0;
    end else begin
      if (pe_begin_prepare && !cur_loaded) begin
        cur_buf[{load_cnt[3:0], 1'b0}] <= current_64pixels[255:0];
        cur_buf[{load_cnt[3:0], 1'b1}] <= current_64pixels[511:256];
        load_cnt   <= load_cnt + 5'd1;
        cur_loaded <= (load_cnt == 5'd15);
      end
      if (ref_begin_prepare) begin
        for (int i = 0; i < 31; i++)
          ref_buf[i] <= ref_buf[i+1];
        ref_buf[31] <= ref_input;
        // The row arriving on the wrap edge is row 0 of the next column.
        if (row_cnt == RCW'(T)) begin
          row_cnt <= RCW'(1);
          col     <= (col == CW'(SEARCH_COLS - 1)) ? '0 : col + 1'b1;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      SAD4x8              <= '0;
      SAD8x4              <= '0;
      SAD8x8              <= '0;
      SAD8x16             <= '0;
      SAD16x8             <= '0;
      SAD16x16            <= '0;
      SAD32x32            <= '0;
      search_column_count <= '0;
      search_row_count    <= '0;
    end else if (capture) begin
      SAD4x8              <= s4x8[12:0];
      SAD8x4              <= s8x4[12:0];
      SAD8x8              <= s8x8[13:0];
      SAD8x16             <= s8x16[14:0];
      SAD16x8             <= s16x8[14:0];
      SAD16x16            <= s16x16[15:0];
      SAD32x32            <= s32x32;
      search_column_count <= col;
      search_row_count    <= k_off[RW-1:0];
    end
  end

endmodule

// File: tb/tb_basic_layer_search.sv
// Directed scoreboard bench for basic_layer_search.
// Expected captures are queued as stimulus is driven and popped on output.
module tb_basic_layer_search;

  logic         clk;
  logic         rst_n;
  logic [255:0] ref_input;
  logic [511:0] current_64pixels;
  logic         ref_begin_prepare;
  logic         pe_begin_prepare;
  logic [12:0]  SAD4x8;
  logic [12:0]  SAD8x4;
  logic [13:0]  SAD8x8;
  logic [14:0]  SAD8x16;
  logic [14:0]  SAD16x8;
  logic [15:0]  SAD16x16;
  logic [17:0]  SAD32x32;
  logic [3:0]   search_column_count;
  logic [3:0]   search_row_count;

  basic_layer_search #(.SEARCH_ROWS(16), .SEARCH_COLS(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ref_input           (ref_input),
    .current_64pixels    (current_64pixels),
    .ref_begin_prepare   (ref_begin_prepare),
    .pe_begin_prepare    (pe_begin_prepare),
    .SAD4x8              (SAD4x8),
    .SAD8x4              (SAD8x4),
    .SAD8x8              (SAD8x8),
    .SAD8x16             (SAD8x16),
    .SAD16x8             (SAD16x8),
    .SAD16x16            (SAD16x16),
    .SAD32x32            (SAD32x32),
    .search_column_count (search_column_count),
    .search_row_count    (search_row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s4x8, s8x4, s8x8, s8x16, s16x8, s16x16, s32x32, kr, kc;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;

  int total = 0;
  int bad   = 0;

  logic [7:0] cur_m [32][32];
  logic [7:0] ref_m [32][32];
  int load_m, rowc_m, col_m;
  bit loaded_m;
  bit cap;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sad_m(input int w, input int h);
    int s = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        s += (cur_m[r][c] > ref_m[r][c]) ? int'(cur_m[r][c]) - int'(ref_m[r][c])
                                         : int'(ref_m[r][c]) - int'(cur_m[r][c]);
    return s;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic compare_all();
    check("sad4x8",   32'(SAD4x8),   held.s4x8);
    check("sad8x4",   32'(SAD8x4),   held.s8x4);
    check("sad8x8",   32'(SAD8x8),   held.s8x8);
    check("sad8x16",  32'(SAD8x16),  held.s8x16);
    check("sad16x8",  32'(SAD16x8),  held.s16x8);
    check("sad16x16", 32'(SAD16x16), held.s16x16);
    check("sad32x32", 32'(SAD32x32), held.s32x32);
    check("row_cnt",  32'(search_row_count),    held.kr);
    check("col_cnt",  32'(search_column_count), held.kc);
  endtask

  task automatic do_reset();
    ref_begin_prepare = 1'b0;
    pe_begin_prepare  = 1'b0;
    ref_input         = '0;
    current_64pixels  = '0;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        cur_m[r][c] = 8'd0;
        ref_m[r][c] = 8'd0;
      end
    load_m = 0; loaded_m = 0; rowc_m = 0; col_m = 0;
    exp_q.delete();
    held = '{default: 32'd0};
    #3;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  task automatic step(input bit pe, input logic [511:0] cur,
                      input bit rv, input logic [255:0] rr);
    exp_t e;
    pe_begin_prepare  = pe;
    current_64pixels  = cur;
    ref_begin_prepare = rv;
    ref_input         = rr;
    cap = 0;
    if (rv && loaded_m && rowc_m >= 32) begin
      e.s4x8   = sad_m(4, 8);
      e.s8x4   = sad_m(8, 4);
      e.s8x8   = sad_m(8, 8);
      e.s8x16  = sad_m(8, 16);
      e.s16x8  = sad_m(16, 8);
      e.s16x16 = sad_m(16, 16);
      e.s32x32 = sad_m(32, 32);
      e.kr     = rowc_m - 32;
      e.kc     = col_m;
      exp_q.push_back(e);
      cap = 1;
    end
    if (pe && !loaded_m) begin
      for (int c = 0; c < 32; c++) begin
        cur_m[2*load_m][c]   = cur[8*c +: 8];
        cur_m[2*load_m+1][c] = cur[256 + 8*c +: 8];
      end
      load_m++;
      if (load_m == 16) loaded_m = 1;
    end
    if (rv) begin
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 32; c++) ref_m[r][c] = ref_m[r+1][c];
      for (int c = 0; c < 32; c++) ref_m[31][c] = rr[8*c +: 8];
      if (rowc_m == 47) begin
        rowc_m = 1;
        col_m  = (col_m == 15) ? 0 : col_m + 1;
      end else begin
        rowc_m++;
      end
    end
    @(posedge clk); #1;
    if (exp_q.size() > 0) held = exp_q.pop_front();
    compare_all();
  endtask

  initial begin
    logic [7:0] bv;
    int n;
    bit seen15, wrapped;

    rst_n = 1'b0;
    do_reset();

    // Reset while the current block is half loaded.
    for (int i = 0; i < 5; i++) step(1, {rnd256(), rnd256()}, 1, rnd256());
    do_reset();

    // Uniform data: ref 0x55 from step 1, current 0x35 from step 10.
    n = 0;
    for (int s = 1; s <= 100 && !cap; s++)
      step(s >= 10, {64{8'h35}}, 1, {32{8'h55}});
    check("uni_cap_seen", 32'(cap), 32'd1);
    check("uni_4x8",   32'(SAD4x8),   32'd1024);
    check("uni_8x4",   32'(SAD8x4),   32'd1024);
    check("uni_8x8",   32'(SAD8x8),   32'd2048);
    check("uni_8x16",  32'(SAD8x16),  32'd4096);
    check("uni_16x8",  32'(SAD16x8),  32'd4096);
    check("uni_16x16", 32'(SAD16x16), 32'd8192);
    check("uni_32x32", 32'(SAD32x32), 32'd32768);
    check("uni_k0",    32'(search_row_count), 32'd0);

    // Pause mid-column, then resume at the next offset.
    for (int i = 0; i < 5; i++) step(0, '0, 1, {32{8'h55}});
    for (int i = 0; i < 5; i++) step(0, '0, 0, {32{8'hAA}});
    check("pause_hold_k", 32'(search_row_count), 32'd5);
    step(0, '0, 1, {32{8'h55}});
    check("resume_k", 32'(search_row_count), 32'd6);

    // Offset sweep: current zero, ref row r has value r.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, '0, 0, '0);
    for (int r = 0; r < 48; r++) begin
      bv = 8'(r);
      step(0, '0, 1, {32{bv}});
      if (r >= 32) begin
        check("sweep_sad32", 32'(SAD32x32), 32'(1024 * (r - 32) + 15872));
        check("sweep_k",     32'(search_row_count), 32'(r - 32));
        check("sweep_col",   32'(search_column_count), 32'd0);
      end
    end

    // Widest values: current 0x00 vs ref 0xFF.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, '0, 0, '0);
    for (int i = 0; i < 33; i++) step(0, '0, 1, {32{8'hFF}});
    check("sat_32x32", 32'(SAD32x32), 32'd261120);
    check("sat_16x16", 32'(SAD16x16), 32'd65280);
    check("sat_4x8",   32'(SAD4x8),   32'd8160);
    check("sat_8x4",   32'(SAD8x4),   32'd8160);

    // Column wrap with random data and concurrent loading.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, {rnd256(), rnd256()}, 1, rnd256());
    seen15 = 0; wrapped = 0; n = 0;
    while (!wrapped && n < 1000) begin
      step(0, '0, 1, rnd256());
      if (col_m == 15) seen15 = 1;
      if (seen15 && col_m == 0) wrapped = 1;
      n++;
    end
    check("wrap_reached", 32'(wrapped), 32'd1);
    check("wrap_prev_col", 32'(search_column_count), 32'd15);
    for (int i = 0; i < 32; i++) step(0, '0, 1, rnd256());
    check("wrap_col0", 32'(search_column_count), 32'd0);
    check("wrap_k0",   32'(search_row_count),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/basic_layer_search.md
Name: basic_layer_search

Overview:
Integer-pel full-search SAD engine for one 32x32 current block in the HEVC motion-estimation datapath. It stores the current block (64 pixels/cycle) and streams a 32-pixel-wide reference strip row by row. For every vertical candidate offset in each search column, it outputs registered SADs of the top-left partition of each supported size, tagged with the candidate coordinates, to the downstream best-match selector.

Parameters:
SEARCH_ROWS, 16, vertical candidate offsets per search column (0..SEARCH_ROWS-1)
SEARCH_COLS, 16, search columns (reference strips) before the column counter wraps

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1), codebase port name kept
ref_input  input  256  one reference row, 32 pixels; bits [8j+7:8j] = column j
current_64pixels  input  512  two current-block rows; [255:0] = even row 2n, [511:256] = odd row 2n+1, same pixel order
ref_begin_prepare  input  1  level: accept ref_input this cycle
pe_begin_prepare  input  1  level: accept current_64pixels this cycle while the current block is loading
SAD4x8  output  13  SAD, cols 0..3, rows 0..7
SAD8x4  output  13  SAD, cols 0..7, rows 0..3
SAD8x8  output  14  SAD, cols 0..7, rows 0..7
SAD8x16  output  15  SAD, cols 0..7, rows 0..15
SAD16x8  output  15  SAD, cols 0..15, rows 0..7
SAD16x16  output  16  SAD, cols 0..15, rows 0..15
SAD32x32  output  18  SAD, whole block
search_column_count  output  clog2(SEARCH_COLS)  column index of the candidate currently on the SAD outputs
search_row_count  output  clog2(SEARCH_ROWS)  vertical offset of the candidate currently on the SAD outputs

Behaviour:
- Partition naming is WxH (width x height). Pixels are unsigned 8-bit; SAD = sum of |cur - ref|; widths above are exact maxima, no saturation.
- Reset: all outputs 0, current buffer C[0..31] and ref buffer R[0..31] cleared, load_cnt=0, row_cnt=0, col=0, cur_loaded=0. Reset can assert at any time and aborts loading or search immediately.
- Current load: on an edge with pe_begin_prepare=1 and load_cnt<16: C[2*load_cnt] <= low half, C[2*load_cnt+1] <= high half, load_cnt++. When load_cnt reaches 16, cur_loaded=1. After that, pe_begin_prepare is ignored until reset. Deasserting pe_begin_prepare pauses loading without losing progress.
- Reference stream: on an edge with ref_begin_prepare=1, R shifts up (R[i] <= R[i+1], R[31] <= ref_input). R[0] is the oldest row and is aligned with C[0]. Loading is independent of the current-block state.
- row_cnt counts rows accepted in the current column. Let T = 31+SEARCH_ROWS. On an accepting edge, if row_cnt==T then row_cnt <= 1 (the incoming row is row 0 of the next column) and col <= (col==SEARCH_COLS-1) ? 0 : col+1. Otherwise row_cnt++. With ref_begin_prepare=0, all of R, row_cnt and col hold.
- Candidate evaluation: candidate offset k = row_cnt-32 exists when row_cnt>=32. On an accepting edge with cur_loaded=1 and row_cnt>=32, the SAD outputs register the combinational SADs of the pre-edge R vs C. On the same edge, search_row_count <= row_cnt-32 and search_column_count <= col (pre-edge values). Latency: 1 cycle from the final row of a candidate being present in R.
- If no capture occurs (ref paused, cur not loaded, or row_cnt<32), all SAD outputs and counts hold their last values. Rows streamed before cur_loaded still advance row_cnt/col; those candidates are skipped, not queued.
- Simultaneous pe and ref activity is legal every cycle.

Test Plan:
- Reset mid-stream: assert rst_n=1 during loading -> all outputs 0; nothing captured until the current block is reloaded and 32 new rows arrive.
- Uniform data: ref rows all 0x55 from cycle 1; pe_begin_prepare from cycle 10 with all 0x35 -> first capture at offset 0, col 0: SAD4x8=1024, SAD8x4=1024, SAD8x8=2048, SAD8x16=4096, SAD16x8=4096, SAD16x16=8192, SAD32x32=32768.
- Offset sweep: current rows = 0. Ref row index r filled with value r, for T+1 rows -> capture k gives SAD32x32 = 32*sum_{i=0..31}(k+i); search_row_count goes 0..15, then col increments to 1.
- Pause: drop ref_begin_prepare for 5 cycles mid-column -> outputs and counts hold, then resume at the next offset.
- Saturation of width: current block all 0x00, ref all 0xFF -> SAD32x32=261120, SAD16x16=65280, SAD4x8=8160.
- Column wrap: stream SEARCH_COLS*(T+1) rows -> search_column_count returns to 0 after column 15.
